// File: rtl/rgb_fade_ctrl.sv
// rgb_fade_ctrl: host-programmed colour fader, sole master of the rgb_led write port.
// Latency: STEP_DIV wait cycles, then 1 step cycle, then R/G/B duty writes on 3 consecutive cycles.
// Backpressure: none; rgb_led accepts every write strobe, host registers are always ready.
//
// Ports: pclk/nreset clock and async active-low reset; bus_* host register port
// (combinational read, single-cycle write strobe); led_* registered write port to
// rgb_led; fade_irq fade-complete interrupt.
// Build option: define RGB_FADE_CTRL_IRQ_EN to build fade_irq as a registered copy of
// STATUS.done; otherwise fade_irq is tied low.
module rgb_fade_ctrl #(
    parameter int         DUTY_W     = 8,
    parameter int         DIV_W      = 16,
    parameter logic [7:0] LED_R_ADDR = 8'h00,
    parameter logic [7:0] LED_G_ADDR = 8'h04,
    parameter logic [7:0] LED_B_ADDR = 8'h08
) (
    input  logic        pclk,
    input  logic        nreset,
    input  logic        bus_write_en,
    input  logic        bus_read_en,
    input  logic [7:0]  bus_addr,
    input  logic [31:0] bus_write_data,
    output logic [31:0] bus_read_data,
    output logic        led_write_en,
    output logic [7:0]  led_addr,
    output logic [31:0] led_write_data,
    output logic        fade_irq
);

    localparam int CW = 3 * DUTY_W;

    localparam logic [7:0] A_CTRL    = 8'h00;
    localparam logic [7:0] A_TARGET  = 8'h04;
    localparam logic [7:0] A_DIV     = 8'h08;
    localparam logic [7:0] A_STATUS  = 8'h0C;
    localparam logic [7:0] A_COLOR_B = 8'h10;

    typedef enum logic [2:0] {IDLE, WAIT, STEP, WR_R, WR_G, WR_B} state_t;

    state_t              state, state_nxt;
    logic [DIV_W-1:0]    cnt, cnt_nxt, div_lim;
    logic [CW-1:0]       current, cur_nxt, stepped;
    logic [CW-1:0]       target, color_b;
    logic [DIV_W-1:0]    step_div;
    logic                enable, loop, done;
    logic                set_done, do_swap;
    logic                led_en_nxt;
    logic [7:0]          led_addr_nxt;
    logic [DUTY_W-1:0]   led_duty, led_duty_nxt;
    logic                unused_wdata;

    assign unused_wdata = ^bus_write_data[31:CW];

    // Moves one channel a single count toward its target; never overshoots.
    function automatic logic [DUTY_W-1:0] step_ch(input logic [DUTY_W-1:0] c,
                                                  input logic [DUTY_W-1:0] t);
        if (c < t)      return c + 1'b1;
        else if (c > t) return c - 1'b1;
        else            return c;
    endfunction

    assign stepped = {step_ch(current[CW-1 -: DUTY_W],     target[CW-1 -: DUTY_W]),
                      step_ch(current[2*DUTY_W-1 -: DUTY_W], target[2*DUTY_W-1 -: DUTY_W]),
                      step_ch(current[DUTY_W-1:0],         target[DUTY_W-1:0])};

    // STEP_DIV of 0 is treated as 1, so the compare value is 0 in both cases.
    assign div_lim = (step_div == '0) ? '0 : step_div - 1'b1;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cur_nxt      = current;
        set_done     = 1'b0;
        do_swap      = 1'b0;
        led_en_nxt   = 1'b0;
        led_addr_nxt = '0;
        led_duty_nxt = '0;
        case (state)
            IDLE: begin
                if (enable && (current != target)) begin
                    state_nxt = WAIT;
                    cnt_nxt   = '0;
                end
            end
            WAIT: begin
                // >= rather than == so a STEP_DIV shrunk mid-wait still fires.
                if (!enable)              state_nxt = IDLE;
                else if (cnt >= div_lim)  state_nxt = STEP;
                else                      cnt_nxt   = cnt + 1'b1;
            end
            STEP: begin
                cur_nxt      = stepped;
                state_nxt    = WR_R;
                led_en_nxt   = 1'b1;
                led_addr_nxt = LED_R_ADDR;
                led_duty_nxt = stepped[CW-1 -: DUTY_W];
            end
            WR_R: begin
                state_nxt    = WR_G;
                led_en_nxt   = 1'b1;
                led_addr_nxt = LED_G_ADDR;
                led_duty_nxt = current[2*DUTY_W-1 -: DUTY_W];
            end
            WR_G: begin
                state_nxt    = WR_B;
                led_en_nxt   = 1'b1;
                led_addr_nxt = LED_B_ADDR;
                led_duty_nxt = current[DUTY_W-1:0];
            end
            WR_B: begin
                cnt_nxt = '0;
                if (current == target) begin
                    set_done = 1'b1;
                    if (loop && enable) begin
                        do_swap   = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    state_nxt = enable ? WAIT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output strobes are registered off next-state so they line up with WR_* cycles.
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            state        <= IDLE;
            cnt          <= '0;
            current      <= '0;
            led_write_en <= 1'b0;
            led_addr     <= '0;
            led_duty     <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            current      <= cur_nxt;
            led_write_en <= led_en_nxt;
            led_addr     <= led_addr_nxt;
            led_duty     <= led_duty_nxt;
        end
    end

    assign led_write_data = {{(32-DUTY_W){1'b0}}, led_duty};

    // Host registers; the loop-mode endpoint swap overrides a same-cycle host write.
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            enable   <= 1'b0;
            loop     <= 1'b0;
            target   <= '0;
            step_div <= DIV_W'(1);
            color_b  <= '0;
            done     <= 1'b0;
        end else begin
            if (bus_write_en) begin
                case (bus_addr)
                    A_CTRL:    begin enable <= bus_write_data[0]; loop <= bus_write_data[1]; end
                    A_TARGET:  target   <= bus_write_data[CW-1:0];
                    A_DIV:     step_div <= bus_write_data[DIV_W-1:0];
                    A_COLOR_B: color_b  <= bus_write_data[CW-1:0];
                    default:   ;
                endcase
            end
            if (do_swap) begin
                target  <= color_b;
                color_b <= target;
            end
            if (set_done)
                done <= 1'b1;
            else if (bus_write_en && (bus_addr == A_STATUS))
                done <= 1'b0;
        end
    end

    always_comb begin
        bus_read_data = '0;
        if (bus_read_en) begin
            case (bus_addr)
                A_CTRL:    bus_read_data[1:0]       = {loop, enable};
                A_TARGET:  bus_read_data[CW-1:0]    = target;
                A_DIV:     bus_read_data[DIV_W-1:0] = step_div;
                A_STATUS: begin
                    bus_read_data[0]      = (state != IDLE);
                    bus_read_data[1]      = done;
                    bus_read_data[8 +: CW] = current;
                end
                A_COLOR_B: bus_read_data[CW-1:0]    = color_b;
                default:   bus_read_data = '0;
            endcase
        end
    end

`ifdef RGB_FADE_CTRL_IRQ_EN
    logic irq_q;
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) irq_q <= 1'b0;
        else         irq_q <= done;
    end
    assign fade_irq = irq_q;
`else
    assign fade_irq = 1'b0;
`endif

endmodule
